dmem_mmio_responder: RTL
========================

Name: dmem_mmio_responder

Overview:
- Responder on the CPU31 data-memory bus: the slave end of the dmem_ena/dmem_w/dmem_r/dmem_addr/dmem_wdata/dmem_rdata protocol the CPU drives.
- Decodes raw CPU byte addresses: backing word RAM plus a small memory-mapped I/O page (cycle counter, periodic timer, LFSR random source, button latch, display register).
- Replaces the bare DMEM plus external address-offset arithmetic in the single-cycle top.

Parameters:
- RAM_BASE, 32'h10010000, byte base of the RAM window.
- RAM_DEPTH, 1024, RAM words (power of 2); window size RAM_DEPTH*4 bytes.
- IO_BASE, 32'h10020000, byte base of the MMIO page (64 bytes).
- LFSR_SEED, 32'h1, RAND reset value; a value of 0 is replaced by 32'h1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- dmem_ena  in  1  bus access enable.
- dmem_w  in  1  write strobe, qualified by dmem_ena.
- dmem_r  in  1  read strobe, qualified by dmem_ena.
- dmem_addr  in  32  raw CPU byte address; bits[1:0] ignored.
- dmem_wdata  in  32  write data.
- dmem_rdata  out  32  read data, combinational.
- btn  in  4  asynchronous push buttons.
- disp_val  out  32  DISP register contents.
- timer_irq  out  1  level copy of TIMER_STAT bit0.
- bus_err  out  1  one-cycle pulse on an unmapped access.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Access rules:
  - rd = dmem_ena & dmem_r; wr = dmem_ena & dmem_w.
  - Writes commit at the rising edge.
  - dmem_rdata is combinational from the address and current state (single-cycle CPU, zero read latency).
  - dmem_rdata = 0 when rd=0.
  - rd and wr together: rdata shows the pre-write value; the write commits at the edge.
- RAM decode:
  - RAM_BASE <= addr < RAM_BASE+4*RAM_DEPTH; index = (addr-RAM_BASE)>>2.
  - RAM contents are not reset.
- MMIO map (offset from IO_BASE):
  - 0x00 CYCLE, RO: free-running 32-bit up-counter; reset 0; wraps 0xFFFFFFFF->0.
  - 0x04 TIMER_CMP, RW: reset 0.
    - A write loads both cmp and the down-counter tcnt.
    - cmp=0: timer stopped.
    - cmp!=0: tcnt decrements each cycle; when tcnt==1, set stat[0] and reload tcnt<=cmp. Period is cmp cycles.
  - 0x08 TIMER_STAT, R/W1C: bit0 expired, bit1 overrun (expiry while bit0 already 1). Reset 0.
    - Writing a 1 to a bit clears it.
    - If a clear and an expiry occur in the same cycle, the expiry wins: bit0 stays 1 and bit1 is not set.
  - 0x0C RAND, RO: Galois LFSR, polynomial 0x80200003; advances every cycle; reset LFSR_SEED.
  - 0x10 BTN, RO: bits[3:0] 2-FF-synchronized level, bits[7:4] sticky rising-edge flags, others 0.
    - An rd to BTN clears the sticky bits at that edge.
    - A rising edge in the same cycle as the clearing read keeps its bit set.
  - 0x14 DISP, RW: drives disp_val; reset 0.
  - 0x18-0x3F: unmapped.
- Unmapped access (outside RAM and MMIO, any unmapped offset, or a write to an RO register):
  - Reads return 0; writes are ignored.
  - bus_err is registered: high for exactly the cycle after the access edge.
- Reset outputs: dmem_rdata=0, disp_val=0, timer_irq=0, bus_err=0.
- Reset asserted mid-timer-period: tcnt=0, cmp=0; the timer is stopped until TIMER_CMP is rewritten.

Optional Feature:
- Macro: DMEM_MMIO_RAND_EN.
- Defined: RAND register and LFSR are implemented as above.
- Undefined: no LFSR logic; offset 0x0C is unmapped (reads 0, asserts bus_err).

Test Plan:
- Write 0xDEADBEEF to 0x10010004, read 0x10010004 -> rdata 0xDEADBEEF. Read 0x10010000 after writing 0x11 there -> 0x11. Byte address 0x10010007 -> same word as 0x10010004.
- Write TIMER_CMP=5 -> stat[0]/timer_irq rise 5 cycles after the write edge, then every 5 cycles. Second expiry without a clear -> stat=0x3. Write 0x1 to STAT on an expiry cycle -> bit0 remains 1.
- Reset, then read RAND each cycle with LFSR_SEED=1 -> sequence 0x1, 0x80200003, ... matches the reference model. Without DMEM_MMIO_RAND_EN -> reads 0 and bus_err pulses.
- Pulse btn[2] high for 3 cycles -> BTN reads 0x40 after release. Next read -> 0x00.
- Read 0x00000000, write 0x10020000 (CYCLE, RO) -> rdata 0, CYCLE unaffected, bus_err high exactly one cycle after each access.
- Assert rst mid-operation (CYCLE=1234, DISP=0xA5) -> next cycle CYCLE=0, disp_val=0, timer stopped; RAM word previously written still reads back unchanged.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// rtl/dmem_mmio_responder.sv - CPU31 data-memory responder: word RAM plus MMIO page
// Define DMEM_MMIO_RAND_EN to build the RAND register and its LFSR.
module dmem_mmio_responder #(
   parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
   parameter int          RAM_DEPTH = 1024,
   parameter logic [31:0] IO_BASE   = 32'h1002_0000,
   parameter logic [31:0] LFSR_SEED = 32'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dmem_ena,
   input  logic        dmem_w,
   input  logic        dmem_r,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   input  logic [3:0]  btn,
   output logic [31:0] disp_val,
   output logic        timer_irq,
   output logic        bus_err
);
   localparam int          AW        = $clog2(RAM_DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_DEPTH * 4);
   localparam logic [3:0]  OFF_CYCLE = 4'd0;
   localparam logic [3:0]  OFF_CMP   = 4'd1;
   localparam logic [3:0]  OFF_STAT  = 4'd2;
   localparam logic [3:0]  OFF_RAND  = 4'd3;
   localparam logic [3:0]  OFF_BTN   = 4'd4;
   localparam logic [3:0]  OFF_DISP  = 4'd5;

   logic          rd, wr;
   logic [31:0]   ram_off;
   logic          ram_hit, io_acc;
   logic [3:0]    io_sel;
   logic [AW-1:0] ram_idx;
   logic [31:0]   mem [RAM_DEPTH];

   logic [31:0]   cycle_cnt, cmp, tcnt, disp;
   logic [1:0]    stat, stat_clr;
   logic [3:0]    btn_s1, btn_s2, btn_s3, btn_sticky;
   logic          rand_ok;
   logic [31:0]   rand_val;
   logic          rd_ok, wr_ok, expire;
   logic [31:0]   rdata_mux;

   assign rd      = dmem_ena & dmem_r;
   assign wr      = dmem_ena & dmem_w;
   // Unsigned wrap makes addresses below RAM_BASE fall outside the window too.
   assign ram_off = dmem_addr - RAM_BASE;
   assign ram_hit = ram_off < RAM_BYTES;
   assign ram_idx = ram_off[AW+1:2];
   assign io_acc  = ~ram_hit & (dmem_addr[31:6] == IO_BASE[31:6]);
   assign io_sel  = dmem_addr[5:2];

`ifdef DMEM_MMIO_RAND_EN
   localparam logic [31:0] SEED = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
   localparam logic [31:0] POLY = 32'h8020_0003;
   logic [31:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= SEED;
      else     lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
   end
   assign rand_val = lfsr;
   assign rand_ok  = 1'b1;
`else
   assign rand_val = 32'h0;
   assign rand_ok  = 1'b0;
   if (LFSR_SEED == 32'h0) begin : g_seed_unused
   end
`endif

   always_comb begin
      rd_ok     = 1'b0;
      wr_ok     = 1'b0;
      rdata_mux = 32'h0;
      if (ram_hit) begin
         rd_ok     = 1'b1;
         wr_ok     = 1'b1;
         rdata_mux = mem[ram_idx];
      end else if (io_acc) begin
         case (io_sel)
            OFF_CYCLE: begin rd_ok = 1'b1; rdata_mux = cycle_cnt; end
            OFF_CMP:   begin rd_ok = 1'b1; wr_ok = 1'b1; rdata_mux = cmp; end
            OFF_STAT:  begin rd_ok = 1'b1; wr_ok = 1'b1; rdata_mux = {30'h0, stat}; end
            OFF_RAND:  begin rd_ok = rand_ok; rdata_mux = rand_val; end
            OFF_BTN:   begin rd_ok = 1'b1; rdata_mux = {24'h0, btn_sticky, btn_s2}; end
            OFF_DISP:  begin rd_ok = 1'b1; wr_ok = 1'b1; rdata_mux = disp; end
            default:   ;
         endcase
      end
   end

   assign dmem_rdata = (rd & rd_ok & ~rst) ? rdata_mux : 32'h0;
   assign expire     = (cmp != 32'h0) & (tcnt == 32'd1);
   assign stat_clr   = (wr & io_acc & (io_sel == OFF_STAT)) ? dmem_wdata[1:0] : 2'b00;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt  <= 32'h0;
         cmp        <= 32'h0;
         tcnt       <= 32'h0;
         stat       <= 2'b00;
         disp       <= 32'h0;
         btn_s1     <= 4'h0;
         btn_s2     <= 4'h0;
         btn_s3     <= 4'h0;
         btn_sticky <= 4'h0;
         bus_err    <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         bus_err   <= (rd & ~rd_ok) | (wr & ~wr_ok);
         if (wr & io_acc & (io_sel == OFF_CMP)) begin
            cmp  <= dmem_wdata;
            tcnt <= dmem_wdata;
         end else if (cmp != 32'h0) begin
            tcnt <= (tcnt == 32'd1) ? cmp : tcnt - 32'd1;
         end
         // An expiry outranks a same-cycle clear of bit0 and then does not count as overrun.
         stat[0] <= expire | (stat[0] & ~stat_clr[0]);
         stat[1] <= (expire & stat[0] & ~stat_clr[0]) | (stat[1] & ~stat_clr[1]);
         if (wr & io_acc & (io_sel == OFF_DISP)) disp <= dmem_wdata;
         btn_s1     <= btn;
         btn_s2     <= btn_s1;
         btn_s3     <= btn_s2;
         btn_sticky <= ((rd & io_acc & (io_sel == OFF_BTN)) ? 4'h0 : btn_sticky)
                       | (btn_s2 & ~btn_s3);
      end
   end

   always_ff @(posedge clk) begin
      if (wr & ram_hit & ~rst) mem[ram_idx] <= dmem_wdata;
   end

   assign timer_irq = stat[0];
   assign disp_val  = disp;
endmodule
